chacha_stream_ctrl: RTL and testbench

//  Sequencer that drives the byte-serial ChaCha20 block core as a keystream generator.

---
 rtl/chacha_stream_ctrl.sv | 162 ++++++++++++++++
 tb/tb_chacha_stream_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chacha_stream_ctrl.sv
// ChaCha20 keystream sequencer: loads the block core, drains bytes, steps the counter.
// Optional CHACHA_CTRL_XOR_EN: XOR a message stream into the keystream output.
module chacha_stream_ctrl #(
  parameter int NBLK_W = 8,
  parameter int CTR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [5:0]        cfg_addr,
  input  logic [7:0]        cfg_data,
  input  logic              start,
  input  logic              abort,
  input  logic [NBLK_W-1:0] num_blocks,
  output logic              busy,
  output logic              done,
  output logic              ctr_wrap,
  output logic              blk_rst,
  output logic [7:0]        blk_data_in,
  output logic              blk_write,
  output logic              blk_read,
  input  logic              blk_ready,
  input  logic [7:0]        blk_data_out,
  output logic [7:0]        ks_data,
  output logic              ks_valid,
`ifdef CHACHA_CTRL_XOR_EN
  input  logic [7:0]        msg_data,
  input  logic              msg_valid,
  output logic              msg_ready,
`endif
  input  logic              ks_ready
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_STREAM = 2'd3;

  localparam logic [127:0] SIGMA =
    128'h6b206574_79622d32_3320646e_61707865;

  logic [1:0]        r_state;
  logic [5:0]        r_idx;
  logic [255:0]      r_key;
  logic [95:0]       r_nonce;
  logic [CTR_W-1:0]  r_ctr;
  logic [NBLK_W-1:0] r_left;
  logic              r_inf;
  logic              r_done;
  logic              r_wrap;
  logic              r_blk_rst;

  logic [31:0]  w_ctr32;
  logic [31:0]  w_ctr_wr;
  logic [5:0]   w_noff;
  logic [511:0] w_state;
  logic         w_stream;
  logic         w_last;

  assign w_ctr32  = 32'(r_ctr);
  assign w_noff   = cfg_addr - 6'd32;
  assign w_state  = {r_nonce, w_ctr32, r_key, SIGMA};
  assign w_stream = (r_state == S_STREAM);

  always_comb begin
    w_ctr_wr = w_ctr32;
    w_ctr_wr[{cfg_addr[1:0], 3'b000} +: 8] = cfg_data;
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign ctr_wrap    = r_wrap;
  assign blk_rst     = r_blk_rst;
  assign blk_write   = (r_state == S_LOAD);
  assign blk_data_in = w_state[{r_idx, 3'b000} +: 8];

`ifdef CHACHA_CTRL_XOR_EN
  assign ks_data   = blk_data_out ^ msg_data;
  assign ks_valid  = w_stream & msg_valid;
  assign msg_ready = w_stream & ks_ready;
`else
  assign ks_data   = blk_data_out;
  assign ks_valid  = w_stream;
`endif

  assign blk_read = ks_valid & ks_ready;
  assign w_last   = blk_read & (r_idx == 6'd63);

  // Block core is held in reset during rst and for one cycle after an abort.
  always_ff @(posedge clk) begin
    if (rst) r_blk_rst <= 1'b1;
    else     r_blk_rst <= abort & busy;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_key   <= '0;
      r_nonce <= '0;
      r_ctr   <= '0;
      r_left  <= '0;
      r_inf   <= 1'b0;
      r_done  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (cfg_we) begin
          if (cfg_addr < 6'd32)
            r_key[{cfg_addr[4:0], 3'b000} +: 8] <= cfg_data;
          else if (cfg_addr < 6'd44)
            r_nonce[{w_noff[3:0], 3'b000} +: 8] <= cfg_data;
          else if (cfg_addr < 6'd48)
            r_ctr <= CTR_W'(w_ctr_wr);
        end
        if (start && !abort) begin
          r_state <= S_LOAD;
          r_idx   <= '0;
          r_left  <= num_blocks;
          r_inf   <= (num_blocks == '0);
          r_wrap  <= 1'b0;
        end
      end else if (abort) begin
        r_state <= S_IDLE;
        r_idx   <= '0;
      end else begin
        case (r_state)
          S_LOAD: begin
            r_idx <= r_idx + 6'd1;
            if (r_idx == 6'd63) r_state <= S_WAIT;
          end
          S_WAIT: begin
            if (blk_ready) r_state <= S_STREAM;
          end
          S_STREAM: begin
            if (blk_read) r_idx <= r_idx + 6'd1;
            // A wrapped counter would repeat keystream, so the run stops here.
            if (w_last) begin
              if (&r_ctr) begin
                r_ctr   <= '0;
                r_wrap  <= 1'b1;
                r_state <= S_IDLE;
              end else begin
                r_ctr  <= r_ctr + 1'b1;
                r_left <= r_left - 1'b1;
                if (!r_inf && r_left == NBLK_W'(1)) begin
                  r_state <= S_IDLE;
                  r_done  <= 1'b1;
                end else begin
                  r_state <= S_LOAD;
                end
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_chacha_stream_ctrl.sv
// Directed bench for chacha_stream_ctrl with a behavioural ChaCha20 block core.
module tb_chacha_stream_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we;
  logic [5:0] cfg_addr;
  logic [7:0] cfg_data;
  logic       start;
  logic       abort;
  logic [7:0] num_blocks;
  logic       busy, done, ctr_wrap, blk_rst;
  logic [7:0] blk_data_in;
  logic       blk_write, blk_read, blk_ready;
  logic [7:0] blk_data_out;
  logic [7:0] ks_data;
  logic       ks_valid, ks_ready;

  always #5 clk = ~clk;

  chacha_stream_ctrl dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .abort(abort), .num_blocks(num_blocks),
    .busy(busy), .done(done), .ctr_wrap(ctr_wrap),
    .blk_rst(blk_rst), .blk_data_in(blk_data_in),
    .blk_write(blk_write), .blk_read(blk_read),
    .blk_ready(blk_ready), .blk_data_out(blk_data_out),
    .ks_data(ks_data), .ks_valid(ks_valid), .ks_ready(ks_ready)
  );

  localparam logic [127:0] SIGMA =
    128'h6b206574_79622d32_3320646e_61707865;

  function automatic logic [127:0] qr(
    input logic [31:0] a, b, c, d);
    a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
    c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
    a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
    c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
    return {a, b, c, d};
  endfunction

  function automatic logic [511:0] chacha_blk(input logic [511:0] st);
    logic [31:0]  x [16];
    logic [31:0]  s [16];
    logic [511:0] res;
    for (int i = 0; i < 16; i++) begin
      s[i] = st[32*i +: 32];
      x[i] = s[i];
    end
    for (int r = 0; r < 10; r++) begin
      {x[0], x[4], x[8],  x[12]} = qr(x[0], x[4], x[8],  x[12]);
      {x[1], x[5], x[9],  x[13]} = qr(x[1], x[5], x[9],  x[13]);
      {x[2], x[6], x[10], x[14]} = qr(x[2], x[6], x[10], x[14]);
      {x[3], x[7], x[11], x[15]} = qr(x[3], x[7], x[11], x[15]);
      {x[0], x[5], x[10], x[15]} = qr(x[0], x[5], x[10], x[15]);
      {x[1], x[6], x[11], x[12]} = qr(x[1], x[6], x[11], x[12]);
      {x[2], x[7], x[8],  x[13]} = qr(x[2], x[7], x[8],  x[13]);
      {x[3], x[4], x[9],  x[14]} = qr(x[3], x[4], x[9],  x[14]);
    end
    for (int i = 0; i < 16; i++) res[32*i +: 32] = x[i] + s[i];
    return res;
  endfunction

  // Behavioural block core: 64 loads, short latency, 64 reads.
  logic [511:0] m_lmem, m_ks;
  logic [5:0]   m_wcnt, m_rcnt;
  logic         m_rdy;
  int           m_lat;

  assign blk_ready    = m_rdy;
  assign blk_data_out = m_ks[{m_rcnt, 3'b000} +: 8];

  always @(posedge clk) begin
    if (blk_rst) begin
      m_wcnt <= '0;
      m_rcnt <= '0;
      m_rdy  <= 1'b0;
      m_lat  <= 0;
      m_ks   <= '0;
    end else begin
      if (blk_write) begin
        m_lmem[{m_wcnt, 3'b000} +: 8] <= blk_data_in;
        m_wcnt <= m_wcnt + 6'd1;
        if (m_wcnt == 6'd63) m_lat <= 3;
      end
      if (m_lat != 0) begin
        m_lat <= m_lat - 1;
        if (m_lat == 1) begin
          m_ks   <= chacha_blk(m_lmem);
          m_rdy  <= 1'b1;
          m_rcnt <= '0;
        end
      end
      if (blk_read && m_rdy) begin
        m_rcnt <= m_rcnt + 6'd1;
        if (m_rcnt == 6'd63) m_rdy <= 1'b0;
      end
    end
  end

  logic [7:0] loadq [$];
  logic [7:0] ksq [$];
  int n_read = 0;
  int n_done = 0;
  int done_at = 0;

  always @(posedge clk) begin
    if (blk_write) loadq.push_back(blk_data_in);
    if (ks_valid && ks_ready) ksq.push_back(ks_data);
    if (blk_read) n_read <= n_read + 1;
    if (done) begin
      n_done  <= n_done + 1;
      done_at <= ksq.size();
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  logic [255:0] tkey;
  logic [95:0]  tnonce;
  int lb, kb, rb, db;

  function automatic int ld(input int i);
    return int'(loadq[lb + i]);
  endfunction

  task automatic mark();
    lb = loadq.size();
    kb = ksq.size();
    rb = n_read;
    db = n_done;
  endtask

  task automatic cfg_wr(input int addr, input logic [7:0] data);
    cfg_we   = 1'b1;
    cfg_addr = 6'(addr);
    cfg_data = data;
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  task automatic set_ctr(input logic [31:0] c);
    for (int k = 0; k < 4; k++) cfg_wr(44 + k, c[8*k +: 8]);
  endtask

  task automatic start_run(input logic [7:0] nb);
    mark();
    num_blocks = nb;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_to_write", int'(blk_write), 1);
  endtask

  task automatic wait_idle(input int budget);
    int i = 0;
    while (busy && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk("run_ends", int'(busy), 0);
  endtask

  task automatic chk_blk(input string tag, input int base,
                         input logic [31:0] c);
    logic [511:0] e;
    e = chacha_blk({tnonce, c, tkey, SIGMA});
    for (int j = 0; j < 64; j++)
      chk(tag, int'(ksq[base + j]), int'(e[8*j +: 8]));
  endtask

  logic [63:0] rfc;

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    start = 1'b0; abort = 1'b0; num_blocks = '0; ks_ready = 1'b1;
    m_lmem = '0;
    for (int k = 0; k < 32; k++) tkey[8*k +: 8] = 8'(k);
    tnonce = '0;
    tnonce[31:24] = 8'h09;
    tnonce[63:56] = 8'h4a;
    rfc = 64'h15593bd1_e4e7f110;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_wrap", int'(ctr_wrap), 0);
    chk("rst_write", int'(blk_write), 0);
    chk("rst_read", int'(blk_read), 0);
    chk("rst_valid", int'(ks_valid), 0);
    chk("rst_blkrst", int'(blk_rst), 1);
    rst = 1'b0;
    @(negedge clk);
    chk("blkrst_release", int'(blk_rst), 0);

    // RFC 8439 block: key 00..1f, counter 1
    for (int k = 0; k < 32; k++) cfg_wr(k, tkey[8*k +: 8]);
    for (int k = 0; k < 12; k++) cfg_wr(32 + k, tnonce[8*k +: 8]);
    set_ctr(32'd1);
    start_run(8'd1);
    wait_idle(1000);
    chk("done_pulse", int'(done), 1);
    @(negedge clk);
    chk("done_drop", int'(done), 0);
    chk("ld_b0", ld(0), 'h65);
    chk("ld_b1", ld(1), 'h78);
    chk("ld_b2", ld(2), 'h70);
    chk("ld_b3", ld(3), 'h61);
    chk("ld_key0", ld(16), 'h00);
    chk("ld_key31", ld(47), 'h1f);
    chk("ld_ctr", ld(48), 'h01);
    chk("ld_nonce3", ld(55), 'h09);
    for (int j = 0; j < 8; j++)
      chk("rfc_ks", int'(ksq[kb + j]), int'(rfc[8*j +: 8]));
    chk_blk("ks_ctr1", kb, 32'd1);
    chk("reads_1", n_read - rb, 64);
    chk("dones_1", n_done - db, 1);

    // Counter carries into the next run; config writes while busy are dropped
    start_run(8'd1);
    cfg_wr(44, 8'h77);
    wait_idle(1000);
    @(negedge clk);
    chk("ld_ctr2", ld(48), 'h02);
    chk_blk("ks_ctr2", kb, 32'd2);

    // Backpressure with ks_ready toggling every cycle
    start_run(8'd1);
    for (int i = 0; i < 2000 && busy; i++) begin
      @(negedge clk);
      ks_ready = ~ks_ready;
    end
    ks_ready = 1'b1;
    chk("bp_idle", int'(busy), 0);
    @(negedge clk);
    chk("bp_ctr_kept", ld(48), 'h03);
    chk("bp_reads", n_read - rb, 64);
    chk("bp_count", ksq.size() - kb, 64);
    chk_blk("bp_ks", kb, 32'd3);

    // Three blocks from counter 0
    set_ctr(32'd0);
    start_run(8'd3);
    wait_idle(3000);
    @(negedge clk);
    chk("nb3_loads", loadq.size() - lb, 192);
    chk("nb3_ctr0", ld(48), 0);
    chk("nb3_ctr1", ld(112), 1);
    chk("nb3_ctr2", ld(176), 2);
    chk("nb3_bytes", ksq.size() - kb, 192);
    chk("nb3_dones", n_done - db, 1);
    chk("nb3_done_at", done_at - kb, 192);
    chk("nb3_last_ks", int'(ksq[kb + 128]),
        int'(chacha_blk({tnonce, 32'd2, tkey, SIGMA}) & 512'hff));

    // Counter wrap stops the run after one block
    set_ctr(32'hffff_ffff);
    start_run(8'd2);
    wait_idle(2000);
    @(negedge clk);
    chk("wrap_flag", int'(ctr_wrap), 1);
    chk("wrap_dones", n_done - db, 0);
    chk("wrap_bytes", ksq.size() - kb, 64);
    chk("wrap_loads", loadq.size() - lb, 64);
    chk("wrap_ld_ctr", ld(51), 'hff);
    start_run(8'd1);
    chk("wrap_clear", int'(ctr_wrap), 0);
    wait_idle(1000);
    @(negedge clk);
    chk("wrap_ctr_lo", ld(48), 0);
    chk("wrap_ctr_hi", ld(51), 0);

    // Abort mid-stream in second block of an unbounded run
    set_ctr(32'd5);
    start_run(8'd0);
    for (int i = 0; i < 5000 && (ksq.size() - kb) < 74; i++)
      @(negedge clk);
    chk("abort_reach", ksq.size() - kb, 74);
    chk("abort_valid", int'(ks_valid), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_idle", int'(busy), 0);
    chk("abort_blkrst", int'(blk_rst), 1);
    @(negedge clk);
    chk("abort_blkrst_1cyc", int'(blk_rst), 0);
    chk("abort_nodone", n_done - db, 0);
    abort = 1'b1;
    start = 1'b1;
    num_blocks = 8'd1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    chk("abort_beats_start", int'(busy), 0);
    cfg_wr(45, 8'h01);
    start_run(8'd1);
    wait_idle(1000);
    @(negedge clk);
    chk("abort_ctr_lo", ld(48), 'h06);
    chk("abort_cfg_hi", ld(49), 'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
